// File: rtl/bpf_seq_ctrl.sv
// Band-pass filter relay sequencer: selects a band from freq and switches relays via mute/switch/settle.
// Optional hysteresis around band edges is enabled by defining BPF_HYST_EN.
module bpf_seq_ctrl #(
  parameter int N_BANDS    = 5,
  parameter int FREQ_W     = 16,
  parameter int SEL_W      = 3,
  parameter int HYST       = 2,
  parameter int MUTE_CYC   = 4,
  parameter int SETTLE_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FREQ_W-1:0] freq,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [FREQ_W-1:0] cfg_thr,
  input  logic [SEL_W-1:0]  cfg_code,
  output logic [SEL_W-1:0]  bpf,
  output logic [2:0]        band,
  output logic              mute,
  output logic              busy,
  output logic              chg
);

  localparam int CNT_MAX = (MUTE_CYC > SETTLE_CYC) ? MUTE_CYC : SETTLE_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUTE,
    S_SWITCH,
    S_SETTLE
  } state_e;

  function automatic logic [FREQ_W-1:0] thrReset(input int idx);
    case (idx)
      0:       return FREQ_W'(38);
      1:       return FREQ_W'(91);
      2:       return FREQ_W'(191);
      3:       return FREQ_W'(305);
      default: return '1;
    endcase
  endfunction

  function automatic logic [SEL_W-1:0] codeReset(input int idx);
    case (idx)
      0:       return SEL_W'(6);
      1:       return SEL_W'(2);
      2:       return SEL_W'(0);
      3:       return SEL_W'(3);
      4:       return SEL_W'(1);
      default: return '0;
    endcase
  endfunction

  // Hysteresis edges saturate so a band edge near 0 or full scale never wraps.
  function automatic logic [FREQ_W-1:0] satAdd(input logic [FREQ_W-1:0] t);
    logic [FREQ_W:0] s;
    s = {1'b0, t} + (FREQ_W+1)'(HYST);
    return s[FREQ_W] ? '1 : s[FREQ_W-1:0];
  endfunction

  function automatic logic [FREQ_W-1:0] satSub(input logic [FREQ_W-1:0] t);
    logic [FREQ_W:0] d;
    d = {1'b0, t} - (FREQ_W+1)'(HYST);
    return ({1'b0, t} < (FREQ_W+1)'(HYST)) ? '0 : d[FREQ_W-1:0];
  endfunction

  logic [FREQ_W-1:0] thr_q  [N_BANDS];
  logic [SEL_W-1:0]  code_q [N_BANDS];
  logic [FREQ_W-1:0] freq_q;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        band_q, band_d;
  logic [SEL_W-1:0]  bpf_q, bpf_d;
  logic              chg_q, chg_d;
  logic [2:0]        latBand_q, latBand_d;
  logic [SEL_W-1:0]  latCode_q, latCode_d;

  logic [2:0]        rawBand;
  logic [2:0]        candBand;
  logic [SEL_W-1:0]  candCode;

  // Out-of-range addresses never match any index and are dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_BANDS; i++) begin
      if (reset) begin
        thr_q[i]  <= thrReset(i);
        code_q[i] <= codeReset(i);
      end else if (cfg_we && (cfg_addr == 3'(i))) begin
        thr_q[i]  <= cfg_thr;
        code_q[i] <= cfg_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      freq_q <= '0;
    end else begin
      freq_q <= freq;
    end
  end

  // First match wins; the last band's threshold is never consulted.
  always_comb begin
    rawBand = 3'(N_BANDS-1);
    for (int i = N_BANDS-2; i >= 0; i--) begin
      if (freq_q <= thr_q[i]) begin
        rawBand = 3'(i);
      end
    end
  end

`ifdef BPF_HYST_EN
  logic [FREQ_W-1:0] thrCur;
  logic [FREQ_W-1:0] thrBelow;
  logic              goUp;
  logic              goDown;

  always_comb begin
    thrCur   = '1;
    thrBelow = '0;
    for (int i = 0; i < N_BANDS; i++) begin
      if (band_q == 3'(i)) begin
        thrCur = thr_q[i];
      end
    end
    for (int i = 0; i < N_BANDS-1; i++) begin
      if (band_q == 3'(i+1)) begin
        thrBelow = thr_q[i];
      end
    end
    goUp     = (band_q < 3'(N_BANDS-1)) && (freq_q > satAdd(thrCur));
    goDown   = (band_q != 3'd0) && (freq_q <= satSub(thrBelow));
    candBand = (goUp || goDown) ? rawBand : band_q;
  end
`else
  always_comb begin
    candBand = rawBand;
  end
`endif

  always_comb begin
    candCode = '0;
    for (int i = 0; i < N_BANDS; i++) begin
      if (candBand == 3'(i)) begin
        candCode = code_q[i];
      end
    end
  end

  // The candidate band and code are frozen on entry to MUTE so later freq or
  // table edits only take effect on the next pass through IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    band_d    = band_q;
    bpf_d     = bpf_q;
    chg_d     = 1'b0;
    latBand_d = latBand_q;
    latCode_d = latCode_q;
    case (state_q)
      S_IDLE: begin
        if ((candBand != band_q) || (candCode != bpf_q)) begin
          state_d   = S_MUTE;
          cnt_d     = '0;
          latBand_d = candBand;
          latCode_d = candCode;
        end
      end
      S_MUTE: begin
        if (cnt_q == CNT_W'(MUTE_CYC-1)) begin
          state_d = S_SWITCH;
          cnt_d   = '0;
          band_d  = latBand_q;
          bpf_d   = latCode_q;
          chg_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SWITCH: begin
        state_d = S_SETTLE;
        cnt_d   = '0;
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC-1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      band_q    <= '0;
      bpf_q     <= codeReset(0);
      chg_q     <= 1'b0;
      latBand_q <= '0;
      latCode_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      band_q    <= band_d;
      bpf_q     <= bpf_d;
      chg_q     <= chg_d;
      latBand_q <= latBand_d;
      latCode_q <= latCode_d;
    end
  end

  assign bpf  = bpf_q;
  assign band = band_q;
  assign chg  = chg_q;
  assign busy = (state_q != S_IDLE);
  assign mute = (state_q != S_IDLE);

endmodule
